// File: rtl/rr_mux5to1.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux5to1
// Description : Five-input round-robin merge into one registered valid/ready
//               output stage. Optional packet lock: RR_MUX5_PKT_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux5to1 #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5*WIDTH-1:0] in_data,
    input  logic [4:0]         in_valid,
    input  logic [4:0]         in_tail,
    output logic [4:0]         in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [2:0]         out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam logic [2:0] c_last_port = 3'd4;

    logic [WIDTH-1:0] r_out_data;
    logic [2:0]       r_out_sel;
    logic             r_out_valid;
    logic [2:0]       r_ptr;

    logic [2:0]       w_ptr_eff;
    logic             w_load;
    logic [4:0]       w_eligible;
    logic [4:0]       w_grant;
    logic [2:0]       w_gidx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_gdata;
    logic [2:0]       w_ptr_next;

    // Index of the port k positions after p, modulo 5.
    function automatic logic [2:0] f_wrap(input logic [2:0] p, input logic [2:0] k);
        logic [3:0] s;
        s = {1'b0, p} + {1'b0, k};
        if (s >= 4'd5) begin
            s = s - 4'd5;
        end
        return s[2:0];
    endfunction

    // Unreachable pointer codes fall back to port 0.
    assign w_ptr_eff = (r_ptr > c_last_port) ? 3'd0 : r_ptr;
    assign w_load    = ~r_out_valid | out_ready;

`ifdef RR_MUX5_PKT_LOCK_EN
    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t r_state;
    logic [2:0]  r_lock_port;

    always_comb begin
        w_eligible = in_valid;
        if (r_state == S_LOCKED) begin
            w_eligible = '0;
            w_eligible[r_lock_port] = in_valid[r_lock_port];
        end
    end
`else
    logic w_unused_tail;
    assign w_unused_tail = ^in_tail;
    assign w_eligible    = in_valid;
`endif

    always_comb begin
        w_grant = '0;
        w_gidx  = 3'd0;
        for (int k = 0; k < 5; k++) begin
            if ((w_grant == 5'd0) && w_eligible[f_wrap(w_ptr_eff, 3'(k))]) begin
                w_grant[f_wrap(w_ptr_eff, 3'(k))] = 1'b1;
                w_gidx = f_wrap(w_ptr_eff, 3'(k));
            end
        end
    end

    always_comb begin
        w_gdata = '0;
        for (int i = 0; i < 5; i++) begin
            if (w_grant[i]) begin
                w_gdata = w_gdata | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready   = (reset || !w_load) ? 5'd0 : w_grant;
    assign w_xfer     = |in_ready;
    assign w_ptr_next = (w_gidx == c_last_port) ? 3'd0 : (w_gidx + 3'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_sel   <= 3'd0;
            r_out_valid <= 1'b0;
            r_ptr       <= 3'd0;
        end else if (w_load) begin
            if (w_xfer) begin
                r_out_data  <= w_gdata;
                r_out_sel   <= w_gidx;
                r_out_valid <= 1'b1;
`ifdef RR_MUX5_PKT_LOCK_EN
                // Pointer moves past a port only once its packet has ended.
                if (in_tail[w_gidx]) begin
                    r_ptr <= w_ptr_next;
                end
`else
                r_ptr <= w_ptr_next;
`endif
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef RR_MUX5_PKT_LOCK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_lock_port <= 3'd0;
        end else if (w_xfer) begin
            case (r_state)
                S_IDLE: begin
                    if (!in_tail[w_gidx]) begin
                        r_state     <= S_LOCKED;
                        r_lock_port <= w_gidx;
                    end
                end
                S_LOCKED: begin
                    if (in_tail[w_gidx]) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`endif

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux5to1.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux5to1
// Description : Directed self-checking bench for rr_mux5to1 (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux5to1;

    localparam int WIDTH = 8;

    logic               clk;
    logic               reset;
    logic [5*WIDTH-1:0] in_data;
    logic [4:0]         in_valid;
    logic [4:0]         in_tail;
    logic [4:0]         in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_sel;
    logic               out_valid;
    logic               out_ready;

    int total;
    int bad;

    rr_mux5to1 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_tail   (in_tail),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] sel, input logic [7:0] data);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".sel"}, 32'(out_sel), 32'(sel));
        chk({tag, ".data"}, 32'(out_data), 32'(data));
    endtask

    logic [2:0] exp_lock [5];
    logic       tail1    [5];

    initial begin
        total = 0;
        bad   = 0;
        reset     = 1'b1;
        in_valid  = 5'b11111;
        in_tail   = 5'b00000;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data[i*WIDTH +: WIDTH] = 8'hA0 + 8'(i);
        end

        // Reset held two cycles with all inputs valid
        tick();
        chk("rst.ready0", 32'(in_ready), 32'd0);
        tick();
        chk("rst.ready1", 32'(in_ready), 32'd0);
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.sel", 32'(out_sel), 32'd0);
        chk("rst.data", 32'(out_data), 32'd0);

        reset = 1'b0;
        #1;
        chk("first.ready", 32'(in_ready), 32'b00001);

        // Rotation 0,1,2,3,4,0
        for (int n = 0; n < 6; n++) begin
            tick();
            chk_out($sformatf("rot%0d", n), 3'(n % 5), 8'hA0 + 8'(n % 5));
        end

        // No valid input: bubble, output fields hold
        in_valid = 5'b00000;
        tick();
        chk("idle.valid", 32'(out_valid), 32'd0);
        chk("idle.sel", 32'(out_sel), 32'd0);
        chk("idle.data", 32'(out_data), 32'hA0);

        // Wrap and skip: grant port3 (ptr->4), then 00101 -> 0 then 2
        in_valid = 5'b01000;
        tick();
        chk_out("p3", 3'd3, 8'hA3);
        in_valid = 5'b00101;
        #1;
        chk("wrap.ready", 32'(in_ready), 32'b00001);
        tick();
        chk_out("wrap0", 3'd0, 8'hA0);
        chk("skip.ready", 32'(in_ready), 32'b00100);
        tick();
        chk_out("skip2", 3'd2, 8'hA2);
        in_valid = 5'b11111;
        #1;
        chk("ptr3.ready", 32'(in_ready), 32'b01000);

        // Backpressure for three cycles
        out_ready = 1'b0;
        #1;
        chk("bp.ready", 32'(in_ready), 32'd0);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk_out($sformatf("bp%0d", n), 3'd2, 8'hA2);
            chk($sformatf("bp%0d.ready", n), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("rel.ready", 32'(in_ready), 32'b01000);
        tick();
        chk_out("rel", 3'd3, 8'hA3);

        // Reset while a flit is buffered and port2 is valid
        in_valid  = 5'b00100;
        out_ready = 1'b0;
        reset     = 1'b1;
        #1;
        chk("mrst.ready", 32'(in_ready), 32'd0);
        tick();
        chk("mrst.valid", 32'(out_valid), 32'd0);
        chk("mrst.ready2", 32'(in_ready), 32'd0);
        chk("mrst.sel", 32'(out_sel), 32'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 5'b11111;
        #1;
        chk("mrst.ptr0", 32'(in_ready), 32'b00001);

        // Port0 transfer puts ptr at 1, then port1 packet vs ports 0 and 3
        in_valid = 5'b00001;
        tick();
        chk_out("pre", 3'd0, 8'hA0);
`ifdef RR_MUX5_PKT_LOCK_EN
        exp_lock = '{3'd1, 3'd1, 3'd1, 3'd3, 3'd0};
`else
        exp_lock = '{3'd1, 3'd3, 3'd0, 3'd1, 3'd3};
`endif
        tail1    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        in_valid = 5'b01011;
        for (int n = 0; n < 5; n++) begin
            in_tail = {4'b0100, 1'b1} | {3'b000, tail1[n], 1'b0};
            tick();
            chk_out($sformatf("pkt%0d", n), exp_lock[n], 8'hA0 + 8'(exp_lock[n]));
        end

        in_valid = 5'b00000;
        tick();
        chk("end.valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_mux5to1.md
Name: rr_mux5to1

Overview:
- Five-input to one-output merge stage for the router datapath. It is the gathering counterpart of the 1-to-5 steering demux: it collects flits from five sources onto a single channel.
- A round-robin arbiter picks one valid input per cycle. The winning flit is registered into a single output stage with a valid/ready handshake.
- The source index is reported on out_sel using the same 3-bit port code as the steering side: 000=port0 … 100=port4.

Parameters:
WIDTH, 1, flit/data width in bits.

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_data  input  5*WIDTH  concatenated input flits, port i at [i*WIDTH +: WIDTH]
in_valid  input  5  per-port flit valid
in_tail  input  5  per-port last-flit-of-packet marker (used only with lock feature)
in_ready  output  5  per-port accept; transfer on port i when in_valid[i] & in_ready[i]
out_data  output  WIDTH  registered selected flit
out_sel  output  3  registered source port code of out_data (0..4)
out_valid  output  1  output register holds a flit
out_ready  input  1  downstream accept; transfer when out_valid & out_ready

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: out_valid=0, out_data=0, out_sel=3'b000, priority pointer ptr=0, lock state=IDLE.
- in_ready is 0 while reset is asserted.
- Load enable: load = ~out_valid | out_ready.
  - load is a combinational function of out_ready, so the path out_ready -> in_ready is combinational.
- Arbitration:
  - Search order starts at ptr: ptr, ptr+1, …, wrapping modulo 5 (4 -> 0).
  - The first port with in_valid set wins. grant is one-hot or all-zero.
- in_ready[i] = load & grant[i]. At most one bit of in_ready is high in any cycle.
- On a transfer from port g:
  - out_data <= flit from port g; out_sel <= g; out_valid <= 1.
  - ptr <= (g==4) ? 0 : g+1.
- If load=1 and no input is valid:
  - out_valid <= 0; out_data and out_sel hold their last values; ptr is unchanged.
- If load=0 (out_valid=1 and out_ready=0):
  - Output register, ptr and all in_ready are held; in_ready=0.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 flit/cycle sustained when out_ready=1. A drain and a new load in the same cycle are allowed, with no bubble.
- Pointer state: ptr holds only the values 0..4; values 5..7 are unreachable. If one is ever reached, the block treats it as 0.
- Protocol rules:
  - An upstream source must hold in_valid and in_data stable until it is accepted.
  - in_valid deasserting without a transfer is legal. The arbiter simply re-evaluates.
- Fairness: any continuously valid port is granted within 5 transfers.
- Reset mid-operation:
  - A buffered flit is discarded, out_valid=0, and ptr returns to 0.
  - No input transfer occurs in the reset cycle.

Optional Feature:
- Macro: RR_MUX5_PKT_LOCK_EN.
- Defined (packet lock): two-state FSM, IDLE/LOCKED(k).
  - IDLE -> LOCKED(g): on a transfer from port g with in_tail[g]=0.
  - While LOCKED(k): only port k is eligible and all other in_ready are 0.
  - LOCKED(k) -> IDLE: on a transfer from port k with in_tail[k]=1.
  - ptr advances only on the tail transfer.
  - A single-flit packet (tail=1 on its first flit) never enters LOCKED.
  - Reset forces IDLE.
- Undefined: in_tail is ignored and arbitration is per-flit as described in Behaviour.

Test Plan:
- Reset then idle: assert reset 2 cycles with in_valid=5'b11111 -> in_ready=0, out_valid=0, out_sel=0; after release, first grant goes to port0.
- Round-robin rotation: in_valid=5'b11111, out_ready=1, port i data=0xA0+i -> out_sel sequence 0,1,2,3,4,0 on consecutive cycles, one per cycle, each out_data matching.
- Wrap and skip: ptr=4 after a grant to port3, in_valid=5'b00101 -> port0 granted, next grant port2, ptr then 3.
- Backpressure: out_ready=0 with out_valid=1 for 3 cycles -> in_ready=0, out_data/out_sel stable. Release out_ready -> buffered flit drains and a new flit loads in the same cycle.
- Reset mid-stream: reset asserted while out_valid=1 and port2 valid -> next cycle out_valid=0, ptr=0, no in_ready pulse during reset.
- Packet lock (macro defined): port1 sends a 3-flit packet (tail on flit 3) while ports 0 and 3 are valid -> out_sel=1,1,1, then 3, then 0. Macro undefined, same stimulus -> out_sel=1,3,0,1,…
